// File: rtl/uart_pkg.sv
// Shared definitions for the wb_uart transmitter and wb_uart_rx receiver.
// Holds the register offsets, the status bit positions and the receive FSM
// state encoding.
package uart_pkg;

  // Register offsets on the 2-bit Wishbone address
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  // Status register bit positions
  localparam int unsigned ST_VALID = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_FERR  = 2;
  localparam int unsigned ST_OVR   = 3;
  localparam int unsigned ST_BUSY  = 4;

  // Receive FSM states
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/wb_uart_rx_if.sv
// Wishbone-classic bus bundle for the UART receiver register port.
//   cyc, stb : bus cycle and (pre-decoded) strobe
//   we       : write enable
//   addr     : 2-bit register offset
//   wdata    : 8-bit write data
//   ack      : one-cycle registered acknowledge
//   stl      : stall, always 0 from this slave
//   rdata    : 8-bit read data, zero outside the ack cycle
interface wb_uart_rx_if;
  logic       cyc;
  logic       stb;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic       stl;
  logic [7:0] rdata;

  modport master (
    output cyc, stb, we, addr, wdata,
    input  ack, stl, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata,
    output ack, stl, rdata
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO.
//   clk, reset : clock and asynchronous active-low reset
//   push, din  : write request and byte; ignored when full unless a pop
//                happens in the same cycle
//   pop        : read request; ignored when empty
//   dout       : head entry (combinational)
//   full,empty : occupancy flags
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_uart_rx.sv
// 8N1 UART receiver with a Wishbone-classic register port.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   wb        : Wishbone slave bundle (offset 0 DATA, offset 1 STATUS)
//   i_uart_rx : asynchronous serial input, idle high
// STATUS = {3'b0, busy, overrun, frame_err, fifo_full, fifo_not_empty};
// bits 3:2 are write-one-to-clear.
module wb_uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  wb_uart_rx_if.slave   wb,
  input  logic          i_uart_rx
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  // Synchroniser
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receive FSM
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          stop_sample;

  always_comb begin
    state_d     = state_q;
    ccnt_d      = ccnt_q;
    bcnt_d      = bcnt_q;
    shreg_d     = shreg_q;
    stop_sample = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          ccnt_d  = HALF_LOAD;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (ccnt_q == '0) begin
          if (!rx_sync_q) begin
            state_d = RX_DATA;
            bcnt_d  = 3'd0;
            ccnt_d  = FULL_LOAD;
          end else begin
            state_d = RX_IDLE;  // glitch: line was high again mid start bit
          end
        end else begin
          ccnt_d = ccnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (ccnt_q == '0) begin
          shreg_d = {rx_sync_q, shreg_q[7:1]};
          ccnt_d  = FULL_LOAD;
          if (bcnt_q == 3'd7) state_d = RX_STOP;
          else                bcnt_d  = bcnt_q + 3'd1;
        end else begin
          ccnt_d = ccnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (ccnt_q == '0) begin
          stop_sample = 1'b1;
          state_d     = RX_IDLE;
        end else begin
          ccnt_d = ccnt_q - 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RX_IDLE;
      ccnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      ccnt_q  <= ccnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Bus decode
  logic req, rd_data_req, wr_status;

  assign req         = wb.cyc & wb.stb;
  assign rd_data_req = req & ~wb.we & (wb.addr == REG_DATA);
  assign wr_status   = req & wb.we & (wb.addr == REG_STATUS);

  // FIFO
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;

  assign fifo_push = stop_sample & rx_sync_q;
  assign fifo_pop  = rd_data_req;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (shreg_q),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Error flags; a hardware set beats a same-cycle W1C.
  logic frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic ferr_set, ovr_set;

  assign ferr_set = stop_sample & ~rx_sync_q;
  // A same-cycle pop makes room, so a full FIFO only overruns without one.
  assign ovr_set  = fifo_push & fifo_full & ~(fifo_pop & ~fifo_empty);

  always_comb begin
    frame_err_d = (frame_err_q & ~(wr_status & wb.wdata[ST_FERR])) | ferr_set;
    overrun_d   = (overrun_q & ~(wr_status & wb.wdata[ST_OVR])) | ovr_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Read mux and registered response
  logic [7:0] status, rd_mux, rdata_d;
  logic       ack_q;
  logic [7:0] rdata_q;

  always_comb begin
    status           = 8'h00;
    status[ST_VALID] = ~fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_FERR]  = frame_err_q;
    status[ST_OVR]   = overrun_q;
    status[ST_BUSY]  = (state_q != RX_IDLE);
    case (wb.addr)
      REG_DATA:   rd_mux = fifo_empty ? 8'h00 : fifo_dout;
      REG_STATUS: rd_mux = status;
      default:    rd_mux = 8'h00;
    endcase
    // Zero outside read acks keeps the shared SoC read bus clean.
    rdata_d = (req & ~wb.we) ? rd_mux : 8'h00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      ack_q   <= req;
      rdata_q <= rdata_d;
    end
  end

  assign wb.ack   = ack_q;
  assign wb.rdata = rdata_q;
  assign wb.stl   = 1'b0;

  logic unused_wdata;
  assign unused_wdata = ^{wb.wdata[7:4], wb.wdata[1:0]};

endmodule

// File: tb/tb_wb_uart_rx.sv
// Directed bench for wb_uart_rx: serial frames driven on i_uart_rx, expected
// bytes queued by the sender and checked against DATA register reads.
module tb_wb_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;

  wb_uart_rx_if wb ();

  wb_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wb        (wb),
    .i_uart_rx (rx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
  endtask

  // One bus request; checks ack timing, read data in the ack cycle and the
  // return of read data to zero afterwards.
  task automatic wb_access(input string tag, input logic we, input logic [1:0] addr,
                           input logic [7:0] wdata, input logic [7:0] exp);
    @(negedge clk);
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we; wb.addr = addr; wb.wdata = wdata;
    check({tag, "_ack_pre"}, {7'd0, wb.ack}, 8'h00);
    @(negedge clk);
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    check({tag, "_ack"}, {7'd0, wb.ack}, 8'h01);
    check({tag, "_data"}, wb.rdata, we ? 8'h00 : exp);
    check({tag, "_stl"}, {7'd0, wb.stl}, 8'h00);
    @(negedge clk);
    check({tag, "_ack_post"}, {7'd0, wb.ack}, 8'h00);
    check({tag, "_data_post"}, wb.rdata, 8'h00);
  endtask

  task automatic rd_status(input string tag, input logic [7:0] exp);
    wb_access(tag, 1'b0, 2'd1, 8'h00, exp);
  endtask

  task automatic rd_data(input string tag);
    logic [7:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    wb_access(tag, 1'b0, 2'd0, 8'h00, exp);
  endtask

  // Sends one frame; abort_bit >= 0 stops halfway through that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == abort_bit) begin
        repeat (CPB / 2) @(negedge clk);
        return;
      end
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    if (stop && exp_q.size() < DEPTH) exp_q.push_back(b);
  endtask

  initial begin
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.addr = 2'd0; wb.wdata = 8'h00;

    // 1: reset
    repeat (3) @(negedge clk);
    check("rst_ack", {7'd0, wb.ack}, 8'h00);
    check("rst_stl", {7'd0, wb.stl}, 8'h00);
    check("rst_rdata", wb.rdata, 8'h00);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    rd_status("t1_status", 8'h00);
    rd_data("t1_data");

    // 2: one good byte
    send_frame(8'hA5, 1'b1, -1);
    rd_status("t2_status", 8'h01);
    rd_data("t2_data");
    rd_status("t2_status_after", 8'h00);

    // 3: short low glitch is rejected
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    rd_status("t3_busy", 8'h10);
    repeat (2 * CPB) @(negedge clk);
    rd_status("t3_idle", 8'h00);

    // 4: framing error and W1C
    send_frame(8'h3C, 1'b0, -1);
    rd_status("t4_ferr", 8'h04);
    wb_access("t4_w1c", 1'b1, 2'd1, 8'h04, 8'h00);
    rd_status("t4_cleared", 8'h00);

    // 5: overrun
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1);
    rd_status("t5_full_ovr", 8'h0B);
    for (int i = 0; i < 5; i++) rd_data($sformatf("t5_data%0d", i));
    rd_status("t5_ovr_only", 8'h08);
    wb_access("t5_w1c", 1'b1, 2'd1, 8'h08, 8'h00);
    rd_status("t5_cleared", 8'h00);

    // 6: reset mid-frame, then a clean byte
    send_frame(8'h77, 1'b1, 3);
    reset = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_rst_ack", {7'd0, wb.ack}, 8'h00);
    reset = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    exp_q.delete();
    rd_status("t6_after_rst", 8'h00);
    send_frame(8'h5A, 1'b1, -1);
    rd_status("t6_status", 8'h01);
    rd_data("t6_data");
    rd_status("t6_status_after", 8'h00);
    rd_data("t6_empty");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
